// File: rtl/fir_mc_serial.sv
// Multichannel time-multiplexed FIR filter with one serial MAC (one product per clock).
// Optional macro FIR_SAT_EN: round half-up, shift right by OUT_SHIFT, saturate output to DATA_W bits.
module fir_mc_serial #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int CHANNELS  = 2,
  parameter int OUT_SHIFT = 15,
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS),
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int A_W      = $clog2(TAPS),
`ifdef FIR_SAT_EN
  localparam int OUT_W    = DATA_W
`else
  localparam int OUT_W    = ACC_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  input  logic [CH_W-1:0]   s_axis_data_tuser,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic [OUT_W-1:0]  m_axis_data_tdata,
  output logic [CH_W-1:0]   m_axis_data_tuser,
  input  logic              coef_we,
  input  logic [A_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high; a source
  // holds valid and its payload unchanged until that edge, and valid never waits on ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam int DL_N = CHANNELS * TAPS;
  localparam int DL_W = (DL_N > 1) ? $clog2(DL_N) : 1;

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] dl_q [DL_N];
  logic [A_W-1:0]           wp_q [CHANNELS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [A_W-1:0]           k_q, k_d, rd_q, rd_d;
  logic [CH_W-1:0]          ch_q, ch_d;

  logic                     in_fire, ch_ok, coef_ok, last_tap;
  logic [A_W-1:0]           wp_cur;
  logic [DL_W-1:0]          wr_idx, rd_idx;
  logic signed [ACC_W-1:0]  prod;

  assign in_fire  = (state_q == S_IDLE) && s_axis_data_tvalid;
  assign ch_ok    = {1'b0, s_axis_data_tuser} < (CH_W+1)'(CHANNELS);
  assign coef_ok  = (state_q == S_IDLE) && coef_we && ({1'b0, coef_addr} < (A_W+1)'(TAPS));
  assign last_tap = (k_q == A_W'(TAPS - 1));
  assign wp_cur   = wp_q[s_axis_data_tuser];
  assign wr_idx   = DL_W'(s_axis_data_tuser) * DL_W'(TAPS) + DL_W'(wp_cur);
  // rd_q walks backwards from the newest sample, so tap k sees x[n-k].
  assign rd_idx   = DL_W'(ch_q) * DL_W'(TAPS) + DL_W'(rd_q);
  assign prod     = ACC_W'(coef_q[k_q]) * ACC_W'(dl_q[rd_idx]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    rd_d    = rd_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire && ch_ok) begin
          state_d = S_MAC;
          acc_d   = '0;
          k_d     = '0;
          rd_d    = wp_cur;
          ch_d    = s_axis_data_tuser;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod;
        k_d   = k_q + A_W'(1);
        rd_d  = (rd_q == '0) ? A_W'(TAPS - 1) : rd_q - A_W'(1);
        if (last_tap) state_d = S_OUT;
      end
      S_OUT: begin
        if (m_axis_data_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      ch_q    <= '0;
      for (int i = 0; i < DL_N; i++) dl_q[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) wp_q[c] <= '0;
      for (int t = 0; t < TAPS; t++) coef_q[t] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      ch_q    <= ch_d;
      if (in_fire && ch_ok) begin
        dl_q[wr_idx]            <= s_axis_data_tdata;
        wp_q[s_axis_data_tuser] <= (wp_cur == A_W'(TAPS - 1)) ? '0 : wp_cur + A_W'(1);
      end
      if (coef_ok) coef_q[coef_addr] <= coef_wdata;
    end
  end

  assign s_axis_data_tready = (state_q == S_IDLE);
  assign m_axis_data_tvalid = (state_q == S_OUT);
  assign m_axis_data_tuser  = ch_q;
  assign busy               = (state_q != S_IDLE);
  assign dbg_state_o        = state_q;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  logic signed [ACC_W:0] rnd_sum, rnd_sh;
  logic                  fits;
  assign rnd_sum = {acc_q[ACC_W-1], acc_q} + HALF;
  assign rnd_sh  = rnd_sum >>> OUT_SHIFT;
  // In range when every bit above the DATA_W sign bit matches it.
  assign fits    = (rnd_sh[ACC_W:DATA_W-1] == '0) || (&rnd_sh[ACC_W:DATA_W-1]);
  assign m_axis_data_tdata = fits ? rnd_sh[DATA_W-1:0] :
                             (rnd_sh[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
  assign m_axis_data_tdata = acc_q;
`endif

endmodule

// File: tb/tb_fir_mc_serial.sv
// Directed bench for fir_mc_serial (TAPS=4, CHANNELS=2, 16-bit data/coefs) with an expected-result queue.
// Expected values come from a shift-register convolution model; FIR_SAT_EN selects the output scaling.
module tb_fir_mc_serial;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 4;
  localparam int CHANNELS  = 2;
  localparam int OUT_SHIFT = 15;
  localparam int ACC_W     = DATA_W + COEF_W + 2;
`ifdef FIR_SAT_EN
  localparam int OUT_W     = DATA_W;
`else
  localparam int OUT_W     = ACC_W;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_tvalid, s_tready;
  logic signed [DATA_W-1:0] s_tdata;
  logic [0:0]               s_tuser;
  logic                     m_tvalid, m_tready;
  logic signed [OUT_W-1:0]  m_tdata;
  logic [0:0]               m_tuser;
  logic                     coef_we;
  logic [1:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     busy;
  logic [1:0]               dbg_state;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];
  longint m_coef [TAPS];
  longint hist [CHANNELS][TAPS];

  fir_mc_serial #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tuser(s_tuser),
    .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tuser(m_tuser),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint conv(input longint a);
`ifdef FIR_SAT_EN
    longint r;
    r = (a + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r;
`else
    return a;
`endif
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
  endtask

  // Driver: coefficient write in IDLE; starts and ends on a falling edge.
  task automatic wr_coef(input int addr, input longint d);
    coef_we    = 1'b1;
    coef_addr  = addr[1:0];
    coef_wdata = 16'(d);
    m_coef[addr] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Driver + checker for one sample. hold: cycles of m_tready=0 in OUT.
  // cw_mode 1: try coef[0]=cw during MAC (must be ignored); 2: write coef[0]=cw with the handshake.
  task automatic xfer(input int ch, input longint x, input int hold, input int cw_mode, input longint cw);
    int n;
    longint acc;
    logic [64:0] e;
    for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
    if (cw_mode == 2) m_coef[0] = cw;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += m_coef[k] * hist[ch][k];
    exp_q.push_back({1'(ch), 64'(conv(acc))});

    check("s_tready_idle", s_tready, 1);
    s_tvalid = 1'b1;
    s_tdata  = 16'(x);
    s_tuser  = 1'(ch);
    m_tready = (hold == 0);
    if (cw_mode == 2) begin
      coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'(cw);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    coef_we  = 1'b0;
    check("busy_mac", busy, 1);
    check("s_tready_mac", s_tready, 0);
    n = 1;
    while (!m_tvalid && n < 20) begin
      if (n == 2 && cw_mode == 1) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'(cw);
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    coef_we = 1'b0;
    check("latency", n, TAPS + 1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("tdata", m_tdata, e[63:0]);
    check("tuser", m_tuser, e[64]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_tvalid", m_tvalid, 1);
      check("hold_tdata", m_tdata, e[63:0]);
      check("hold_tuser", m_tuser, e[64]);
      check("hold_s_tready", s_tready, 0);
    end
    m_tready = 1'b1;
    @(negedge clk);
    check("tvalid_drop", m_tvalid, 0);
    check("s_tready_back", s_tready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; m_tready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", s_tready, 1);

    // Impulse response on channel 0
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    xfer(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) xfer(0, 0, 0, 0, 0);

    // Channel isolation
    for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
    for (int i = 0; i < 4; i++) begin
      xfer(0, (i == 0) ? 1 : 0, 0, 0, 0);
      xfer(1, 100, 0, 0, 0);
    end

    // Output backpressure
    xfer(1, 100, 5, 0, 0);

    // Coefficient writes: ignored in MAC, taken in IDLE and with a same-cycle handshake
    xfer(0, 7, 0, 1, 9);
    xfer(0, 7, 0, 0, 0);
    wr_coef(0, 9);
    xfer(0, 7, 0, 0, 0);
    xfer(1, 3, 0, 2, -5);
    xfer(1, 3, 0, 0, 0);

    // Extremes
    for (int k = 0; k < TAPS; k++) wr_coef(k, -32768);
    for (int i = 0; i < 4; i++) xfer(0, -32768, 0, 0, 0);

    // Reset during MAC aborts the computation and clears all state
    s_tvalid = 1'b1; s_tdata = 16'sd5; s_tuser = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_tvalid", m_tvalid, 0);
    check("abort_tdata", m_tdata, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    check("abort_no_output", seen, 0);
    check("abort_s_tready", s_tready, 1);
    model_clear();
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    xfer(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) xfer(0, 0, 0, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
